// File: rtl/thrust_pkg.sv
// Shared types and constants for the thrust source arbiter and the wrapper
// logic that inspects its owner/mode encodings.
package thrust_pkg;

  localparam int THRUST_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'b00,
    OWN_ANALOG  = 2'b01,
    OWN_DIGITAL = 2'b10
  } owner_t;

  typedef enum logic [1:0] {
    MODE_AUTO     = 2'b00,
    MODE_ANALOG   = 2'b01,
    MODE_DIGITAL  = 2'b10,
    MODE_AUTO_ALT = 2'b11
  } mode_t;

  // The spare encoding behaves as auto, so fold it before any comparison;
  // otherwise 00 <-> 11 would look like a mode change.
  function automatic mode_t norm_mode(input logic [1:0] m);
    mode_t r;
    r = (m == 2'b11) ? MODE_AUTO : mode_t'(m);
    return r;
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running 0..TICK_DIV-1 counter with a registered single-cycle strobe
// that is high exactly while the counter holds TICK_DIV-1.
module rate_tick_gen #(
  parameter int TICK_DIV = 98425
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int                CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  PRE   = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      // Raised one count early so the strobe lines up with r_cnt == LAST.
      r_tick <= (r_cnt == PRE);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/thrust_src_arbiter.sv
// Arbitrates the thrust lever between the analog stick and a digital up/down
// ramp, handing ownership over without a jump in the registered thrust value.
module thrust_src_arbiter
  import thrust_pkg::*;
#(
  parameter int TICK_DIV      = 98425,
  parameter int THRUST_MAX    = 254,
  parameter int DEADZONE      = 8,
  parameter int RELEASE_TICKS = 64
) (
  input  logic                clk_25,
  input  logic                RESET_L,
  input  logic [1:0]          mode_sel,
  input  logic signed [7:0]   analog_y,
  input  logic                dig_up,
  input  logic                dig_down,
  output logic [THRUST_W-1:0] thrust,
  output logic [1:0]          owner,
  output logic                ramp_tick
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ANALOG  = 2'b01;
  localparam logic [1:0] ST_DIGITAL = 2'b10;

  localparam int                   REL_W    = $clog2(RELEASE_TICKS + 1);
  localparam logic [REL_W-1:0]     REL_MAX  = REL_W'(RELEASE_TICKS);
  localparam logic [REL_W-1:0]     REL_LAST = REL_W'(RELEASE_TICKS - 1);
  localparam logic [THRUST_W-1:0]  T_MAX    = THRUST_W'(THRUST_MAX);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [THRUST_W-1:0] r_thrust;
  logic [REL_W-1:0]    r_rel;
  mode_t               r_mode;
  mode_t               w_mode;
  logic                w_mode_chg;
  logic                w_tick;

  logic signed [8:0]   w_y9;
  logic signed [9:0]   w_diff;
  logic [8:0]          w_mag;
  logic [THRUST_W-1:0] w_a_val;
  logic [THRUST_W-1:0] w_ramp_val;
  logic                w_a_active;
  logic                w_d_active;
  logic                w_own_active;
  logic                w_rel_done;
  owner_t              w_owner;

  rate_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk_25),
    .rst_n  (RESET_L),
    .o_tick (w_tick)
  );

  // Stick rest is 0; full up (-128) maps to 255 before the clamp.
  assign w_y9   = {analog_y[7], analog_y};
  assign w_diff = 10'sd127 - $signed({w_y9[8], w_y9});
  assign w_mag  = w_y9[8] ? 9'(-w_y9) : w_y9;

  assign w_a_active = (w_mag > 9'(DEADZONE));
  assign w_d_active = dig_up ^ dig_down;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_a_val = w_diff[THRUST_W-1:0];
    if (w_diff < 10'sd0)
      w_a_val = '0;
    else if (w_diff > $signed({2'b00, T_MAX}))
      w_a_val = T_MAX;
  end

  always_comb begin
    w_ramp_val = r_thrust;
    if (dig_up && !dig_down)
      w_ramp_val = (r_thrust >= T_MAX) ? T_MAX : r_thrust + THRUST_W'(1);
    else if (dig_down && !dig_up)
      w_ramp_val = (r_thrust == '0) ? '0 : r_thrust - THRUST_W'(1);
  end

  assign w_mode     = norm_mode(mode_sel);
  assign w_mode_chg = (w_mode != r_mode);

  assign w_own_active = ((r_state == ST_ANALOG)  && w_a_active) ||
                        ((r_state == ST_DIGITAL) && w_d_active);
  assign w_rel_done   = w_tick && !w_own_active && (r_rel >= REL_LAST);

  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_chg) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (w_mode)
        MODE_ANALOG:  w_state_nxt = ST_ANALOG;
        MODE_DIGITAL: w_state_nxt = ST_DIGITAL;
        default: begin
          case (r_state)
            ST_IDLE: begin
              if (w_d_active)      w_state_nxt = ST_DIGITAL;
              else if (w_a_active) w_state_nxt = ST_ANALOG;
            end
            ST_ANALOG: begin
              if (w_d_active)      w_state_nxt = ST_DIGITAL;
              else if (w_rel_done) w_state_nxt = ST_IDLE;
            end
            ST_DIGITAL: begin
              if (w_d_active)      w_state_nxt = ST_DIGITAL;
              else if (w_a_active) w_state_nxt = ST_ANALOG;
              else if (w_rel_done) w_state_nxt = ST_IDLE;
            end
            default:               w_state_nxt = ST_IDLE;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state  <= ST_IDLE;
      r_thrust <= '0;
      r_rel    <= '0;
      r_mode   <= MODE_AUTO;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode;

      if (w_mode_chg || (w_state_nxt != r_state) || w_own_active)
        r_rel <= '0;
      else if (w_tick && (r_rel != REL_MAX))
        r_rel <= r_rel + REL_W'(1);

      // Thrust follows the state being left, so a handoff to DIGITAL ramps
      // from the last analog value and a handoff to ANALOG lands next cycle.
      if (!w_mode_chg) begin
        case (r_state)
          ST_ANALOG:  r_thrust <= w_a_val;
          ST_DIGITAL: if (w_tick) r_thrust <= w_ramp_val;
          default:    r_thrust <= r_thrust;
        endcase
      end
    end
  end

  assign w_owner   = owner_t'(r_state);
  assign owner     = w_owner;
  assign thrust    = r_thrust;
  assign ramp_tick = w_tick;

endmodule

// File: tb/tb_thrust_src_arbiter.sv
// Scoreboard bench for thrust_src_arbiter with a short tick period and
// release window so every ownership path is reachable in a few hundred cycles.
module tb_thrust_src_arbiter;
  import thrust_pkg::*;

  localparam int TICK_DIV      = 4;
  localparam int THRUST_MAX    = 254;
  localparam int DEADZONE      = 8;
  localparam int RELEASE_TICKS = 3;

  logic              clk_25 = 1'b0;
  logic              RESET_L;
  logic [1:0]        mode_sel;
  logic signed [7:0] analog_y;
  logic              dig_up;
  logic              dig_down;
  logic [7:0]        thrust;
  logic [1:0]        owner;
  logic              ramp_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] thr;
    logic [1:0] own;
    bit         chk_thr;
  } exp_t;

  exp_t sb_q[$];

  thrust_src_arbiter #(
    .TICK_DIV      (TICK_DIV),
    .THRUST_MAX    (THRUST_MAX),
    .DEADZONE      (DEADZONE),
    .RELEASE_TICKS (RELEASE_TICKS)
  ) dut (
    .clk_25    (clk_25),
    .RESET_L   (RESET_L),
    .mode_sel  (mode_sel),
    .analog_y  (analog_y),
    .dig_up    (dig_up),
    .dig_down  (dig_down),
    .thrust    (thrust),
    .owner     (owner),
    .ramp_tick (ramp_tick)
  );

  always #20 clk_25 = ~clk_25;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] a_ref(input int y);
    int v;
    v = 127 - y;
    if (v > THRUST_MAX) v = THRUST_MAX;
    if (v < 0) v = 0;
    return 8'(v);
  endfunction

  task automatic push(input string tag, input logic [7:0] thr, input logic [1:0] own,
                      input bit chk_thr);
    exp_t e;
    e.tag = tag; e.thr = thr; e.own = own; e.chk_thr = chk_thr;
    sb_q.push_back(e);
  endtask

  task automatic sb_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_owner"}, 32'(owner), 32'(e.own));
      if (e.chk_thr) check({e.tag, "_thrust"}, 32'(thrust), 32'(e.thr));
    end
  endtask

  task automatic step();
    @(posedge clk_25);
    #1;
  endtask

  // Advance to just past the edge that closes the next ramp_tick cycle.
  task automatic tick_edge();
    int n;
    n = 0;
    while (!ramp_tick && n < 4 * TICK_DIV) begin
      step();
      n++;
    end
    check("tick_seen", 32'(ramp_tick), 1);
    step();
  endtask

  task automatic set_y(input int y);
    analog_y = 8'(y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int mx;
    RESET_L = 1'b0; mode_sel = 2'b00; analog_y = '0; dig_up = 1'b0; dig_down = 1'b0;
    repeat (3) step();
    check("rst_thrust", 32'(thrust), 0);
    check("rst_owner", 32'(owner), 32'(OWN_NONE));
    check("rst_tick", 32'(ramp_tick), 0);

    // Tick timing: counter 0,1,2,3 -> strobe on the fourth counter value.
    @(negedge clk_25);
    RESET_L = 1'b1;
    n = 0;
    while (!ramp_tick && n < 16) begin step(); n++; end
    check("tick_first", n, 3);
    step();
    check("tick_width", 32'(ramp_tick), 0);
    n = 0;
    while (!ramp_tick && n < 16) begin step(); n++; end
    check("tick_period", n, 3);

    // Same-cycle tie from IDLE: digital wins.
    dig_up = 1'b1; set_y(-100);
    push("tie", 8'd0, OWN_DIGITAL, 1);
    step(); sb_cmp();
    dig_up = 1'b0; set_y(0);
    RESET_L = 1'b0; step(); step(); RESET_L = 1'b1;

    // Analog full up, then release after RELEASE_TICKS idle ticks.
    set_y(-128);
    push("an_entry", 8'd0, OWN_ANALOG, 0);
    step(); sb_cmp();
    push("an_full", a_ref(-128), OWN_ANALOG, 1);
    step(); sb_cmp();
    set_y(5);
    push("an_hold", a_ref(5), OWN_ANALOG, 1);
    tick_edge(); tick_edge(); sb_cmp();
    push("an_release", a_ref(5), OWN_NONE, 1);
    tick_edge(); sb_cmp();
    push("idle_hold", a_ref(5), OWN_NONE, 1);
    repeat (3) step();
    sb_cmp();

    // Analog at 127, then seamless handoff to the digital ramp.
    set_y(-20);
    push("an2_entry", 8'd0, OWN_ANALOG, 0);
    step(); sb_cmp();
    set_y(0);
    push("an2_mid", a_ref(0), OWN_ANALOG, 1);
    step(); sb_cmp();
    dig_up = 1'b1;
    push("handoff", 8'd127, OWN_DIGITAL, 1);
    step(); sb_cmp();
    push("ramp_first", 8'd128, OWN_DIGITAL, 1);
    tick_edge(); sb_cmp();
    mx = 0;
    push("ramp_sat", 8'(THRUST_MAX), OWN_DIGITAL, 1);
    for (int i = 0; i < 200; i++) begin
      tick_edge();
      if (32'(thrust) > mx) mx = 32'(thrust);
    end
    sb_cmp();
    check("ramp_peak", mx, THRUST_MAX);

    // Back to analog at thrust 1, then forced digital mode.
    dig_up = 1'b0; set_y(126);
    push("an3", a_ref(126), OWN_ANALOG, 1);
    step(); step(); sb_cmp();
    mode_sel = 2'b10;
    push("dmode_gap", 8'd1, OWN_NONE, 1);
    step(); sb_cmp();
    push("dmode_on", 8'd1, OWN_DIGITAL, 1);
    step(); sb_cmp();
    set_y(0); dig_down = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push("down_floor", 8'd0, OWN_DIGITAL, 1);
      tick_edge(); sb_cmp();
    end
    dig_down = 1'b0; dig_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("up_step", 8'(i + 1), OWN_DIGITAL, 1);
      tick_edge(); sb_cmp();
    end
    dig_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("both_hold", 8'd3, OWN_DIGITAL, 1);
      tick_edge(); sb_cmp();
    end

    // Auto idle, then 00 -> 01 with the stick at 60.
    dig_up = 1'b0; dig_down = 1'b0; mode_sel = 2'b00;
    push("auto_idle", 8'd3, OWN_NONE, 1);
    step(); step(); step(); sb_cmp();
    mode_sel = 2'b01; set_y(60);
    push("amode_gap", 8'd3, OWN_NONE, 1);
    step(); sb_cmp();
    push("amode_on", 8'd3, OWN_ANALOG, 1);
    step(); sb_cmp();
    push("amode_val", a_ref(60), OWN_ANALOG, 1);
    step(); sb_cmp();

    // Reach thrust 50 under digital ownership, then reset asynchronously.
    mode_sel = 2'b00; set_y(77);
    push("auto_gap", a_ref(60), OWN_NONE, 1);
    step(); sb_cmp();
    push("an4_entry", 8'd0, OWN_ANALOG, 0);
    step(); sb_cmp();
    push("an4_val", a_ref(77), OWN_ANALOG, 1);
    step(); sb_cmp();
    dig_up = 1'b1;
    push("pre_reset", 8'd50, OWN_DIGITAL, 1);
    step(); sb_cmp();
    #5 RESET_L = 1'b0;
    #1;
    check("async_thrust", 32'(thrust), 0);
    check("async_owner", 32'(owner), 32'(OWN_NONE));
    check("async_tick", 32'(ramp_tick), 0);
    step();
    check("held_thrust", 32'(thrust), 0);
    check("sb_drained", 32'(sb_q.size()), 0);
    RESET_L = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thrust_src_arbiter.md
Name: thrust_src_arbiter

Overview:
Sequences and arbitrates the lander thrust-lever value between two requesters: the analog stick (absolute position) and digital up/down inputs (D-pad or keyboard, integrated as a rate ramp). It produces the registered 8-bit THRUST value fed to the game core. It sits in the top-level emulation wrapper between the input decoding (joystick and PS/2) and the core's THRUST port. It replaces ad-hoc muxing with an owner FSM, so that switching control sources never causes a thrust jump.

Parameters:
TICK_DIV, 98425, clk_25 cycles per ramp step (254 steps ≈ 1 s at 25 MHz); legal range 2..2^20.
THRUST_MAX, 254, upper clamp for thrust; the lever DAC never produced 0xFF.
DEADZONE, 8, analog deflection magnitude (from stick rest) required to claim ownership.
RELEASE_TICKS, 64, consecutive idle ramp ticks before the owner is released.

Ports:
clk_25  in  1  system clock
RESET_L  in  1  asynchronous active-low reset
mode_sel  in  2  00 auto, 01 analog only, 10 digital only, 11 treated as 00
analog_y  in  8  signed stick Y; -128 = full up
dig_up  in  1  thrust-increase request (joystick OR keyboard), active high
dig_down  in  1  thrust-decrease request, active high
thrust  out  8  thrust value to core
owner  out  2  00 none, 01 analog, 10 digital
ramp_tick  out  1  single-cycle strobe at each ramp step (debug and overlay)

Behaviour:
- Reset:
  - Reset is asynchronous and active-low on RESET_L. Only clk_25 is used.
  - Values while RESET_L=0: thrust=0, owner=00, ramp_tick=0, tick counter=0, release counter=0, FSM in IDLE.
  - Reset takes effect mid-operation with the same values; no partial state survives.
- Tick counter:
  - Free-running from 0 to TICK_DIV-1, then wraps to 0.
  - ramp_tick=1 for exactly the cycle in which the counter equals TICK_DIV-1.
- Analog map:
  - a_val = 127 - analog_y, computed as 9-bit signed and then clamped to [0, THRUST_MAX].
  - Examples: analog_y=-128 gives 254 (255 clamped); analog_y=127 gives 0; analog_y=0 gives 127.
  - a_active = |analog_y| > DEADZONE. The magnitude is computed 9-bit, so -128 is handled correctly.
- Digital ramp (evaluated only on ramp_tick):
  - dig_up & ~dig_down: thrust = min(thrust+1, THRUST_MAX).
  - dig_down & ~dig_up: thrust = max(thrust-1, 0).
  - Both or neither: thrust is held.
  - d_active = dig_up ^ dig_down.
- FSM, auto mode:
  - IDLE: thrust is held.
    - If d_active, go to DIGITAL. Digital wins a same-cycle tie.
    - Else if a_active, go to ANALOG.
  - ANALOG: thrust <= a_val every cycle; owner=01.
    - If d_active, go to DIGITAL. The ramp starts from the current thrust value (seamless handoff, no jump).
    - If ~a_active for RELEASE_TICKS consecutive ramp_ticks, go to IDLE. The last value is held.
  - DIGITAL: the ramp applies; owner=10.
    - If d_active is 0 for RELEASE_TICKS consecutive ramp_ticks, go to IDLE.
    - If a_active while ~d_active, go to ANALOG. thrust is then updated to a_val on the next cycle.
- Release counter:
  - Cleared on any owner activity and on every state change.
  - Saturates at RELEASE_TICKS.
- Forced modes:
  - 01: FSM pinned to ANALOG regardless of a_active.
  - 10: FSM pinned to DIGITAL.
- Mode change:
  - Any change of mode_sel forces IDLE for one cycle with thrust held. The new mode then takes effect.
- Latency:
  - Analog: thrust reflects analog_y 1 cycle after the input is sampled, via registered output.
  - Digital: thrust reflects dig_up/dig_down no later than the next ramp_tick.
- Outputs: all are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package thrust_pkg:
  - typedef owner_t enum {OWN_NONE=2'b00, OWN_ANALOG=2'b01, OWN_DIGITAL=2'b10}.
  - typedef mode_t, with the MODE_* constants.
  - Constant THRUST_W=8.
- One sub-module, rate_tick_gen, containing the tick counter and the ramp_tick strobe. Parameterised by TICK_DIV; the wrapper's overlay timer reuses it.
- The FSM, analog map and ramp live in the top module.

Test Plan (sim: TICK_DIV=4, RELEASE_TICKS=3, DEADZONE=8):
1. RESET_L low mid-ramp at thrust=50 -> thrust=0 and owner=00 immediately (async); after release, ramp_tick first pulses on cycle 4.
2. Auto mode, analog_y=-128 -> owner=01 and thrust=254 one cycle after ANALOG entry. Then analog_y=5 for 3 ticks -> owner=00 and thrust holds at the last a_val.
3. Auto mode, owner analog at thrust=127, pulse dig_up -> owner=10 and thrust=128 at the next ramp_tick (no jump). Hold dig_up for 200 ticks -> thrust saturates at 254, never 255.
4. Digital mode, thrust=1, hold dig_down for 5 ticks -> 0 and stays 0. dig_up and dig_down together -> thrust unchanged.
5. IDLE, same-cycle dig_up=1 and analog_y=-100 -> owner=10 (digital wins the tie).
6. mode_sel 00->01 with analog_y=60 -> one cycle with thrust held and owner=00, then owner=01 and thrust=67.
